// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: FIFO status/read signals, burst control and sink handshake for fifo_rd_ctrl
interface fifo_rd_ctrl_if #(parameter int DATA_W = 32);
    logic              start;
    logic [3:0]        burst_len;
    logic              rd_en;
    logic              empty;
    logic              rd_ack;
    logic              rd_err;
    logic [DATA_W-1:0] dout;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [3:0]        words_done;
    logic [7:0]        err_cnt;
    modport slave (
        input  start, burst_len, empty, rd_ack, rd_err, dout, out_ready,
        output rd_en, out_data, out_valid, busy, done, words_done, err_cnt
    );
    modport master (
        output start, burst_len, empty, rd_ack, rd_err, dout, out_ready,
        input  rd_en, out_data, out_valid, busy, done, words_done, err_cnt
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: burst read engine draining a FIFO into a valid/ready sink
module fifo_rd_ctrl #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic          clk,
    input  logic          reset,
    fifo_rd_ctrl_if.slave bus
);
    localparam int             WCW      = $clog2(TIMEOUT + 1);
    localparam logic [3:0]     MAX_LEN  = 4'(DEPTH);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT - 1);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, HOLD, DONE} state_t;
    state_t            state, state_nx;
    logic [3:0]        remaining, remaining_nx, words_done, words_nx, len;
    logic [WCW-1:0]    wcnt, wcnt_nx;
    logic [7:0]        err_cnt;
    logic [DATA_W-1:0] out_data;
    logic              err_inc, capture;
    assign len = bus.burst_len > MAX_LEN ? MAX_LEN : bus.burst_len;
    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        words_nx     = words_done;
        wcnt_nx      = wcnt;
        err_inc      = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                remaining_nx = len;
                words_nx     = '0;
                state_nx     = len == '0 ? DONE : CHECK;
            end
            CHECK: state_nx = bus.empty ? CHECK : ISSUE;
            ISSUE: begin
                wcnt_nx  = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                if (bus.rd_ack) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end else if (bus.rd_err || wcnt == WAIT_MAX) begin
                    err_inc  = 1'b1;
                    state_nx = CHECK;
                end else begin
                    wcnt_nx = wcnt + 1'b1;
                end
            end
            HOLD: if (bus.out_ready) begin
                words_nx     = words_done + 4'd1;
                remaining_nx = remaining - 4'd1;
                state_nx     = remaining == 4'd1 ? DONE : CHECK;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            words_done <= '0;
            wcnt       <= '0;
            err_cnt    <= '0;
            out_data   <= '0;
        end else begin
            state      <= state_nx;
            remaining  <= remaining_nx;
            words_done <= words_nx;
            wcnt       <= wcnt_nx;
            if (err_inc && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
            if (capture) out_data <= bus.dout;
        end
    end
    assign bus.rd_en      = state == ISSUE;
    assign bus.out_valid  = state == HOLD;
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;
    assign bus.words_done = words_done;
    assign bus.err_cnt    = err_cnt;
    assign bus.out_data   = out_data;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bursts against a FIFO model, scoreboarded words and done summaries
module tb_fifo_rd_ctrl;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    fifo_rd_ctrl_if #(.DATA_W(DW)) ifc();
    fifo_rd_ctrl #(.DATA_W(DW), .DEPTH(8), .TIMEOUT(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(ifc.slave)
    );
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] fifo_mem [64];
    int wr_ptr = 0, rd_ptr = 0;
    int resp_mem [16];
    int rs_wr = 0, rs_rd = 0;
    logic [DW-1:0] exp_mem [64];
    int exp_wr = 0, exp_rd = 0;
    int dn_w [16], dn_e [16], dn_r [16];
    int dn_wr = 0, dn_rd = 0;
    int rd_cnt = 0;
    bit hold_empty = 1'b0;
    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [DW-1:0] w, input bit expect_it);
        fifo_mem[wr_ptr] = w;
        wr_ptr++;
        if (expect_it) begin
            exp_mem[exp_wr] = w;
            exp_wr++;
        end
    endtask
    task automatic add_exp(input logic [DW-1:0] w);
        exp_mem[exp_wr] = w;
        exp_wr++;
    endtask
    task automatic add_done(input int w, input int e, input int r);
        dn_w[dn_wr] = w;
        dn_e[dn_wr] = e;
        dn_r[dn_wr] = r;
        dn_wr++;
    endtask
    task automatic add_resp(input int m);
        resp_mem[rs_wr] = m;
        rs_wr++;
    endtask
    task automatic go(input logic [3:0] len);
        ifc.burst_len = len;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
    endtask
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!ifc.done && n < 200) begin
            tick();
            n++;
        end
        chk(ifc.done === 1'b1, name, n, 200);
        tick();
    endtask
    task automatic chk_zero(input string name);
        chk(ifc.rd_en == 1'b0, {name, "_rd_en"}, ifc.rd_en, 0);
        chk(ifc.out_valid == 1'b0, {name, "_out_valid"}, ifc.out_valid, 0);
        chk(ifc.busy == 1'b0, {name, "_busy"}, ifc.busy, 0);
        chk(ifc.done == 1'b0, {name, "_done"}, ifc.done, 0);
        chk(ifc.words_done == 4'd0, {name, "_words_done"}, ifc.words_done, 0);
        chk(ifc.err_cnt == 8'd0, {name, "_err_cnt"}, ifc.err_cnt, 0);
        chk(ifc.out_data == '0, {name, "_out_data"}, ifc.out_data, 0);
    endtask
    // FIFO model: answers each rd_en one cycle later with ack (popping a word), err, or silence
    initial begin
        bit pend;
        int m;
        pend = 1'b0;
        ifc.empty = 1'b1;
        ifc.rd_ack = 1'b0;
        ifc.rd_err = 1'b0;
        ifc.dout = '0;
        forever begin
            tick();
            ifc.rd_ack = 1'b0;
            ifc.rd_err = 1'b0;
            if (reset) pend = 1'b0;
            if (pend) begin
                m = 0;
                if (rs_rd < rs_wr) begin
                    m = resp_mem[rs_rd];
                    rs_rd++;
                end
                if (m == 0) begin
                    ifc.rd_ack = 1'b1;
                    ifc.dout = fifo_mem[rd_ptr];
                    rd_ptr++;
                end else if (m == 1) begin
                    ifc.rd_err = 1'b1;
                end
                pend = 1'b0;
            end
            if (ifc.rd_en && !reset) pend = 1'b1;
            ifc.empty = hold_empty || rd_ptr == wr_ptr;
        end
    end
    initial begin
        bit prev_hold;
        logic [DW-1:0] prev_data;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
                rd_cnt = 0;
                continue;
            end
            if (prev_hold && ifc.out_valid)
                chk(ifc.out_data == prev_data, "hold_stable", ifc.out_data, prev_data);
            if (ifc.rd_en) begin
                rd_cnt++;
                chk(!ifc.empty, "rd_en_while_empty", ifc.empty, 0);
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_rd < exp_wr) begin
                    chk(ifc.out_data == exp_mem[exp_rd], "out_data", ifc.out_data, exp_mem[exp_rd]);
                    exp_rd++;
                end else chk(1'b0, "unexpected_word", ifc.out_data, 0);
            end
            if (ifc.done) begin
                if (dn_rd < dn_wr) begin
                    chk(ifc.words_done == 4'(dn_w[dn_rd]), "done_words", ifc.words_done, dn_w[dn_rd]);
                    chk(ifc.err_cnt == 8'(dn_e[dn_rd]), "done_err_cnt", ifc.err_cnt, dn_e[dn_rd]);
                    chk(rd_cnt == dn_r[dn_rd], "done_rd_count", rd_cnt, dn_r[dn_rd]);
                    dn_rd++;
                end else chk(1'b0, "unexpected_done", ifc.words_done, 0);
                rd_cnt = 0;
            end
            prev_hold = ifc.out_valid && !ifc.out_ready;
            prev_data = ifc.out_data;
        end
    end
    initial begin
        int n;
        reset = 1'b1;
        ifc.start = 1'b0;
        ifc.burst_len = '0;
        ifc.out_ready = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();
        push(32'hA1, 1); push(32'hA2, 1); push(32'hA3, 1);
        add_done(3, 0, 3);
        tick();
        go(4'd3);
        n = 1;
        while (!ifc.rd_en && n < 20) begin
            tick();
            n++;
        end
        chk(n == 2, "first_rd_latency", n, 2);
        wait_done("basic_done");
        ifc.out_ready = 1'b0;
        push(32'hB1, 1); push(32'hB2, 1);
        add_done(2, 0, 2);
        tick();
        go(4'd2);
        n = 0;
        while (!ifc.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk(ifc.out_valid === 1'b1, "bp_first_valid", n, 50);
        repeat (5) tick();
        chk(ifc.out_valid === 1'b1, "bp_valid_held", ifc.out_valid, 1);
        ifc.out_ready = 1'b1;
        wait_done("bp_done");
        hold_empty = 1'b1;
        add_done(1, 0, 1);
        tick();
        go(4'd1);
        repeat (6) tick();
        push(32'h55, 1);
        hold_empty = 1'b0;
        wait_done("empty_done");
        push(32'hC1, 1);
        add_resp(1); add_resp(2); add_resp(0);
        add_done(1, 2, 3);
        tick();
        go(4'd1);
        n = 0;
        while (ifc.err_cnt != 8'd1 && n < 50) begin
            tick();
            n++;
        end
        chk(ifc.err_cnt == 8'd1, "err_after_rd_err", ifc.err_cnt, 1);
        n = 0;
        while (!ifc.rd_en && n < 50) begin
            tick();
            n++;
        end
        n = 0;
        while (ifc.err_cnt != 8'd2 && n < 50) begin
            tick();
            n++;
        end
        chk(n == 5, "timeout_cycles", n, 5);
        wait_done("err_done");
        add_done(0, 2, 0);
        go(4'd0);
        n = 1;
        while (!ifc.done && n < 5) begin
            tick();
            n++;
        end
        chk(ifc.done === 1'b1 && n <= 2, "len0_done", n, 2);
        tick();
        for (int i = 0; i < 9; i++) push(32'hD0 + 32'(i), i < 8);
        add_done(8, 2, 8);
        tick();
        go(4'd12);
        repeat (10) tick();
        ifc.burst_len = 4'd1;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        wait_done("clamp_done");
        add_exp(32'hD8);
        push(32'hE1, 0); push(32'hE2, 0); push(32'hE3, 0); push(32'hE4, 0);
        tick();
        go(4'd4);
        n = 0;
        while (ifc.words_done != 4'd1 && n < 50) begin
            tick();
            n++;
        end
        ifc.out_ready = 1'b0;
        n = 0;
        while (!ifc.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk(ifc.out_data == 32'hE1, "mid_word2", ifc.out_data, 32'hE1);
        reset = 1'b1;
        tick();
        chk_zero("mid_reset");
        reset = 1'b0;
        ifc.out_ready = 1'b1;
        tick();
        add_exp(32'hE2);
        add_done(1, 0, 1);
        go(4'd1);
        wait_done("post_reset_done");
        chk(exp_rd == exp_wr, "all_words_seen", exp_rd, exp_wr);
        chk(dn_rd == dn_wr, "all_dones_seen", dn_rd, dn_wr);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
